rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Reset sequencer for the AXI-Lite register station subsystem.
- Holds N downstream reset domains in reset after power-on.
- Releases the domains one by one in ascending index order, with programmable spacing.
- Services software reset requests: quiesces the datapath (drains in-flight AXI transactions), re-asserts all domain resets, then replays the release sequence.
- Sits between the top-level reset input and the per-domain reset pins of the register slices.

Parameters:
N_DOMAINS, 3, number of sequenced reset domains (>=1).
ASSERT_HOLD, 4, clock edges all domains are held in reset before the first release (>=1).
RELEASE_DLY, 8, clock edges between consecutive domain releases (>=1).
QUIESCE_TO, 64, max cycles to wait for quiesce_ack; 0 = wait forever.
CNT_W, 8, internal timer width; must hold max(ASSERT_HOLD, RELEASE_DLY, QUIESCE_TO).

Ports:
clk  in  1  clock.
aresetn  in  1  reset, asynchronous, active-low; deassertion is synchronous to clk.
soft_rst_req  in  1  level request for a software reset.
soft_rst_ack  out  1  one-cycle pulse when domain resets are re-asserted.
quiesce_req  out  1  asks the datapath to stop accepting new transactions and drain.
quiesce_ack  in  1  datapath idle/drained.
err_clr  in  1  clears timeout_err.
rst_n_out  out  N_DOMAINS  active-low per-domain resets.
rst_done  out  1  all domains released, sequencer idle.
seq_busy  out  1  high in any state other than RUN.
timeout_err  out  1  sticky flag: quiesce timed out.

Behaviour:
- Clock and reset: clk; aresetn, asynchronous, active-low. All flops are reset by aresetn.
- Reset values: rst_n_out = 0, quiesce_req = 0, soft_rst_ack = 0, rst_done = 0, seq_busy = 1, timeout_err = 0, FSM = HOLD, timer = ASSERT_HOLD, domain index = 0, pending = 0.
- FSM states: HOLD, RELEASE, RUN, QUIESCE, ASSERT.
- HOLD:
  - Timer decrements each edge.
  - On the ASSERT_HOLD-th edge after aresetn deasserts: rst_n_out[0] <= 1, timer <= RELEASE_DLY, go to RELEASE (or RUN if N_DOMAINS == 1).
- RELEASE:
  - Every RELEASE_DLY edges, set rst_n_out[idx+1].
  - On the edge that sets rst_n_out[N_DOMAINS-1]: rst_done <= 1, seq_busy <= 0, go to RUN.
  - Released bits are never cleared except via ASSERT or aresetn.
- Release timing (defaults, edge 1 = first edge with aresetn high): rst_n_out[0] at edge 4, [1] at edge 12, [2] at edge 20; rst_done and !seq_busy at edge 20.
- pending flag:
  - Set by soft_rst_req sampled high in any state except RUN.
  - In RUN, (soft_rst_req | pending) moves the FSM to QUIESCE on the next edge. quiesce_req <= 1, rst_done <= 0, seq_busy <= 1, pending <= 0.
- QUIESCE:
  - Exit when quiesce_ack is sampled high, or when QUIESCE_TO edges elapse (QUIESCE_TO != 0).
  - Timeout exit sets timeout_err.
  - Ack and timeout on the same edge: ack wins, no error.
  - quiesce_ack already high on entry: exit after exactly 1 cycle in QUIESCE.
  - On exit: go to ASSERT with quiesce_req <= 0.
- ASSERT (one cycle):
  - rst_n_out <= 0 (all domains, same edge).
  - soft_rst_ack pulses high for this cycle.
  - timer <= ASSERT_HOLD, idx <= 0, go to HOLD. The sequence then replays with identical timing.
- timeout_err: sticky. Cleared only by err_clr (single edge) or aresetn. If err_clr and a new timeout occur on the same edge, set wins.
- soft_rst_req held high continuously: after one full cycle completes, RUN is re-entered and a new sequence starts immediately. No lockup; rst_done is high for 1 cycle per loop.
- aresetn asserted in any state: immediately forces reset values (asynchronous), including mid-QUIESCE. quiesce_req drops combinationally with the flop reset.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package rst_seq_pkg:
  - typedef enum logic [2:0] rst_seq_state_t {HOLD, RELEASE, RUN, QUIESCE, ASSERT};
  - localparam for the default CNT_W;
  - helper function returning the timer width.
- Sub-module rst_seq_timer: loadable down-counter (load, load_val, en) -> expired. Instanced once and shared by the HOLD, RELEASE and QUIESCE states.
- Elaboration assertions: N_DOMAINS >= 1, ASSERT_HOLD >= 1, RELEASE_DLY >= 1, CNT_W sufficient.

Test Plan:
- Power-on, defaults: deassert aresetn -> rst_n_out = 001 at edge 4, 011 at 12, 111 at 20; rst_done = 1 and seq_busy = 0 at edge 20.
- Soft reset, ack after 5 cycles: in RUN, pulse soft_rst_req 1 cycle -> quiesce_req high next edge; ack raised 5 cycles later -> soft_rst_ack pulse, rst_n_out = 000; release replays (001 at +4, 111 at +20 after ASSERT); timeout_err stays 0.
- Quiesce timeout: quiesce_ack held 0 -> exit after 64 cycles, timeout_err = 1, sequence continues. err_clr pulse -> timeout_err = 0.
- Request during release: soft_rst_req pulse at edge 10 -> pending; the sequence completes, then QUIESCE is entered at edge 21 with no extra rst_done cycles lost.
- Ack/timeout tie and immediate ack: ack rising exactly on the timeout edge -> no error. quiesce_ack constantly 1 -> QUIESCE lasts exactly 1 cycle.
- Async reset mid-QUIESCE: assert aresetn low -> all outputs return to reset values at once; after deassertion the power-on timing of scenario 1 is reproduced exactly.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        RUN,
        QUIESCE,
        ASSERT
    } rst_seq_state_t;

    localparam int RST_SEQ_CNT_W_DFLT = 8;

    // Minimum timer width able to hold the largest of the three delays.
    function automatic int rst_seq_cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter; expired is high while the count sits at 1, so a
// load of D followed by D-1 enabled edges makes the D-th edge see expired.
module rst_seq_timer #(
    parameter int CNT_W   = 8,
    parameter int RST_VAL = 1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // Load has priority; counting stops at zero so a zero load never expires.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            count <= CNT_W'(RST_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, releases them one by one,
// and replays the sequence after a quiesced software reset.
//
// state   | meaning
// --------+-------------------------------------------------------------
// HOLD    | all domains in reset, counting down ASSERT_HOLD
// RELEASE | releasing domains 1..N-1, one every RELEASE_DLY edges
// RUN     | all domains released, waiting for a software reset request
// QUIESCE | quiesce_req high, waiting for quiesce_ack or timeout
// ASSERT  | single cycle with all domains in reset and soft_rst_ack high
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_DOMAINS   = 3,
    parameter int ASSERT_HOLD = 4,
    parameter int RELEASE_DLY = 8,
    parameter int QUIESCE_TO  = 64,
    parameter int CNT_W       = RST_SEQ_CNT_W_DFLT
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 soft_rst_req,
    output logic                 soft_rst_ack,
    output logic                 quiesce_req,
    input  logic                 quiesce_ack,
    input  logic                 err_clr,
    output logic [N_DOMAINS-1:0] rst_n_out,
    output logic                 rst_done,
    output logic                 seq_busy,
    output logic                 timeout_err
);

    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOMAINS - 1);

    if (N_DOMAINS < 1) begin : g_chk_n_domains
        $error("rst_seq_ctrl: N_DOMAINS must be >= 1");
    end
    if (ASSERT_HOLD < 1) begin : g_chk_assert_hold
        $error("rst_seq_ctrl: ASSERT_HOLD must be >= 1");
    end
    if (RELEASE_DLY < 1) begin : g_chk_release_dly
        $error("rst_seq_ctrl: RELEASE_DLY must be >= 1");
    end
    if (CNT_W < rst_seq_cnt_w(ASSERT_HOLD, RELEASE_DLY, QUIESCE_TO)) begin : g_chk_cnt_w
        $error("rst_seq_ctrl: CNT_W too small for the configured delays");
    end

    rst_seq_state_t       state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt, idx_inc;
    logic [N_DOMAINS-1:0] rst_n_nxt;
    logic                 pending, pending_nxt;
    logic                 qreq_nxt, sack_nxt, done_nxt, busy_nxt, terr_nxt;
    logic                 tmr_load, tmr_en, tmr_exp;
    logic [CNT_W-1:0]     tmr_val;

    assign idx_inc = idx + 1'b1;

    // One timer serves the hold, release-spacing and quiesce-timeout phases.
    rst_seq_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ASSERT_HOLD)
    ) u_timer (
        .clk      (clk),
        .aresetn  (aresetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_exp)
    );

    // State and all registered outputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= HOLD;
            idx          <= '0;
            pending      <= 1'b0;
            rst_n_out    <= '0;
            quiesce_req  <= 1'b0;
            soft_rst_ack <= 1'b0;
            rst_done     <= 1'b0;
            seq_busy     <= 1'b1;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            pending      <= pending_nxt;
            rst_n_out    <= rst_n_nxt;
            quiesce_req  <= qreq_nxt;
            soft_rst_ack <= sack_nxt;
            rst_done     <= done_nxt;
            seq_busy     <= busy_nxt;
            timeout_err  <= terr_nxt;
        end
    end

    // Next-state, next-output and timer control.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        rst_n_nxt   = rst_n_out;
        qreq_nxt    = quiesce_req;
        sack_nxt    = 1'b0;
        done_nxt    = rst_done;
        busy_nxt    = seq_busy;
        terr_nxt    = timeout_err;
        pending_nxt = pending;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        tmr_val     = '0;

        if (err_clr) terr_nxt = 1'b0;
        // A request outside RUN is remembered and served once RUN is reached.
        if (soft_rst_req && (state != RUN)) pending_nxt = 1'b1;

        case (state)
            HOLD: begin
                tmr_en = 1'b1;
                if (tmr_exp) begin
                    rst_n_nxt[0] = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_val      = CNT_W'(RELEASE_DLY);
                    if (N_DOMAINS == 1) begin
                        state_nxt = RUN;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end
            end
            RELEASE: begin
                tmr_en = 1'b1;
                if (tmr_exp) begin
                    rst_n_nxt = rst_n_out | (N_DOMAINS'(1) << idx_inc);
                    idx_nxt   = idx_inc;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(RELEASE_DLY);
                    if (idx_inc == LAST_IDX) begin
                        state_nxt = RUN;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (soft_rst_req || pending) begin
                    state_nxt   = QUIESCE;
                    qreq_nxt    = 1'b1;
                    done_nxt    = 1'b0;
                    busy_nxt    = 1'b1;
                    pending_nxt = 1'b0;
                    tmr_load    = 1'b1;
                    tmr_val     = CNT_W'(QUIESCE_TO);
                end
            end
            QUIESCE: begin
                tmr_en = 1'b1;
                // Ack is checked first so a same-edge ack suppresses the error.
                if (quiesce_ack || ((QUIESCE_TO != 0) && tmr_exp)) begin
                    if (!quiesce_ack) terr_nxt = 1'b1;
                    state_nxt = ASSERT;
                    qreq_nxt  = 1'b0;
                    rst_n_nxt = '0;
                    sack_nxt  = 1'b1;
                end
            end
            ASSERT: begin
                rst_n_nxt = '0;
                idx_nxt   = '0;
                tmr_load  = 1'b1;
                tmr_val   = CNT_W'(ASSERT_HOLD);
                state_nxt = HOLD;
            end
            default: begin
                state_nxt = HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl with a phase/edge-count reference model.
module tb_rst_seq_ctrl;

    localparam int N  = 3;
    localparam int AH = 4;
    localparam int RD = 8;
    localparam int QT = 64;
    localparam int W  = N + 5;
    localparam logic [W-1:0] RST_VEC = {{N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Model phases: sequencing, running, quiescing, asserting.
    localparam int P_SEQ = 0;
    localparam int P_RUN = 1;
    localparam int P_QSC = 2;
    localparam int P_AST = 3;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         soft_rst_req = 1'b0;
    logic         quiesce_ack = 1'b0;
    logic         err_clr = 1'b0;
    logic         soft_rst_ack, quiesce_req, rst_done, seq_busy, timeout_err;
    logic [N-1:0] rst_n_out;
    logic [W-1:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    int           m_phase, m_k;
    bit           m_pend, m_qreq, m_sack, m_done, m_busy, m_terr;
    logic [N-1:0] m_rst;

    always #5 clk = ~clk;

    assign obs = {rst_n_out, quiesce_req, soft_rst_ack, rst_done, seq_busy, timeout_err};

    rst_seq_ctrl #(
        .N_DOMAINS   (N),
        .ASSERT_HOLD (AH),
        .RELEASE_DLY (RD),
        .QUIESCE_TO  (QT),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .quiesce_req  (quiesce_req),
        .quiesce_ack  (quiesce_ack),
        .err_clr      (err_clr),
        .rst_n_out    (rst_n_out),
        .rst_done     (rst_done),
        .seq_busy     (seq_busy),
        .timeout_err  (timeout_err)
    );

    function automatic logic [W-1:0] exp_vec();
        return {m_rst, m_qreq, m_sack, m_done, m_busy, m_terr};
    endfunction

    task automatic model_reset();
        m_phase = P_SEQ; m_k = 0; m_pend = 0;
        m_rst = '0; m_qreq = 0; m_sack = 0; m_done = 0; m_busy = 1; m_terr = 0;
    endtask

    // One clock edge of the reference model, fed with the sampled inputs.
    task automatic model_step(input bit req, input bit ack, input bit clr);
        bit pend_set;
        int rel;
        pend_set = req && (m_phase != P_RUN);
        m_sack = 0;
        if (clr) m_terr = 0;
        case (m_phase)
            P_SEQ: begin
                m_k++;
                rel = (m_k < AH) ? 0 : 1 + (m_k - AH) / RD;
                if (rel > N) rel = N;
                m_rst = N'((1 << rel) - 1);
                if (m_k == AH + (N - 1) * RD) begin
                    m_phase = P_RUN; m_done = 1; m_busy = 0;
                end
            end
            P_RUN: begin
                if (req || m_pend) begin
                    m_phase = P_QSC; m_k = 0; m_qreq = 1; m_done = 0; m_busy = 1; m_pend = 0;
                end
            end
            P_QSC: begin
                m_k++;
                if (ack || (QT != 0 && m_k == QT)) begin
                    if (!ack) m_terr = 1;
                    m_phase = P_AST; m_qreq = 0; m_rst = '0; m_sack = 1;
                end
            end
            default: begin
                m_phase = P_SEQ; m_k = 0; m_rst = '0;
            end
        endcase
        if (pend_set) m_pend = 1;
    endtask

    // Drive inputs, advance one edge, step the model, settle past the edge.
    task automatic tick(input bit req, input bit ack, input bit clr);
        soft_rst_req = req; quiesce_ack = ack; err_clr = clr;
        @(posedge clk);
        model_step(req, ack, clr);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0; soft_rst_req = 1'b0; quiesce_ack = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== RST_VEC) begin
                n_err++;
                $display("FAIL reset_values: got %b expected %b", obs, RST_VEC);
            end
        end
    endtask

    task automatic test_power_on();
        do_reset();
        for (int i = 1; i <= 22; i++) begin
            tick(0, 0, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL power_on edge %0d: got %b expected %b", i, obs, exp_vec());
            end
            if (i == 3 || i == 4 || i == 12 || i == 20) begin
                n_cmp++;
                if (rst_n_out !== ((i == 3) ? 3'b000 : (i == 4) ? 3'b001 : (i == 12) ? 3'b011 : 3'b111)) begin
                    n_err++;
                    $display("FAIL power_on_rst_n edge %0d: got %b", i, rst_n_out);
                end
            end
        end
        n_cmp++;
        if (rst_done !== 1'b1 || seq_busy !== 1'b0) begin
            n_err++;
            $display("FAIL power_on_done: got done=%b busy=%b expected done=1 busy=0", rst_done, seq_busy);
        end
    endtask

    task automatic test_soft_reset_ack();
        tick(1, 0, 0);
        n_cmp++;
        if (quiesce_req !== 1'b1 || obs !== exp_vec()) begin
            n_err++;
            $display("FAIL soft_quiesce_entry: got %b expected %b", obs, exp_vec());
        end
        for (int i = 1; i <= 5; i++) begin
            tick(0, (i == 5), 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL soft_quiesce cyc %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if (soft_rst_ack !== 1'b1 || rst_n_out !== 3'b000 || quiesce_req !== 1'b0) begin
            n_err++;
            $display("FAIL soft_assert: got ack=%b rst_n=%b qreq=%b expected 1 000 0", soft_rst_ack, rst_n_out, quiesce_req);
        end
        tick(0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick(0, 0, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL soft_replay +%0d: got %b expected %b", i, obs, exp_vec());
            end
            if (i == 4 || i == 20) begin
                n_cmp++;
                if (rst_n_out !== ((i == 4) ? 3'b001 : 3'b111) || timeout_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL soft_replay_rst_n +%0d: got rst_n=%b terr=%b", i, rst_n_out, timeout_err);
                end
            end
        end
    endtask

    task automatic test_timeout();
        tick(1, 0, 0);
        for (int i = 1; i <= 64; i++) begin
            // err_clr on the timeout edge itself: the new error must win.
            tick(0, 0, (i == 64));
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL timeout cyc %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if (timeout_err !== 1'b1 || soft_rst_ack !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_flag: got terr=%b ack=%b expected 1 1", timeout_err, soft_rst_ack);
        end
        for (int i = 0; i <= 21; i++) begin
            tick(0, 0, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL timeout_replay %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        tick(0, 0, 1);
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr: got %b expected 0", timeout_err);
        end
    endtask

    task automatic test_req_during_release();
        do_reset();
        for (int i = 1; i <= 21; i++) begin
            tick((i == 10), 0, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL req_release edge %0d: got %b expected %b", i, obs, exp_vec());
            end
            if (i == 20 || i == 21) begin
                n_cmp++;
                if (rst_done !== (i == 20) || quiesce_req !== (i == 21)) begin
                    n_err++;
                    $display("FAIL req_release_handoff edge %0d: got done=%b qreq=%b", i, rst_done, quiesce_req);
                end
            end
        end
        for (int i = 0; i < 24; i++) begin
            tick(0, 1, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL req_release_replay %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_tie_and_immediate_ack();
        tick(1, 0, 0);
        for (int i = 1; i <= 64; i++) tick(0, (i == 64), 0);
        n_cmp++;
        if (timeout_err !== 1'b0 || soft_rst_ack !== 1'b1) begin
            n_err++;
            $display("FAIL ack_timeout_tie: got terr=%b ack=%b expected 0 1", timeout_err, soft_rst_ack);
        end
        for (int i = 0; i < 21; i++) tick(0, 0, 0);
        tick(1, 1, 0);
        tick(0, 1, 0);
        n_cmp++;
        if (soft_rst_ack !== 1'b1 || quiesce_req !== 1'b0 || obs !== exp_vec()) begin
            n_err++;
            $display("FAIL immediate_ack: got %b expected %b", obs, exp_vec());
        end
        for (int i = 0; i < 21; i++) begin
            tick(0, 1, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL immediate_replay %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        for (int i = 0; i < 46; i++) begin
            tick(1, 1, 0);
            dones += int'(rst_done);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL back_to_back %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if (dones != 2) begin
            n_err++;
            $display("FAIL back_to_back_done_count: got %0d expected 2", dones);
        end
    endtask

    task automatic test_async_reset_mid_quiesce();
        for (int i = 0; i < 30 && m_phase != P_RUN; i++) tick(0, 1, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        #2 aresetn = 1'b0;
        #1;
        n_cmp++;
        if (obs !== RST_VEC) begin
            n_err++;
            $display("FAIL async_reset: got %b expected %b", obs, RST_VEC);
        end
        test_power_on();
    endtask

    task automatic test_random();
        bit r, a, c;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 29) == 0);
            tick(r, a, c);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_soft_reset_ack();
        test_timeout();
        test_req_during_release();
        test_tie_and_immediate_ack();
        test_back_to_back();
        test_async_reset_mid_quiesce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
